// File: rtl/spi_motor_frame_responder.sv
// SPI slave for the 12-word motor control frame: oversamples the SPI pins, returns status words, commits commands on a clean frame.
// Optional watchdog on pwm_ref is compiled in with `define SPI_WATCHDOG_EN.
module spi_motor_frame_responder #(
  parameter int                 SYNC_STAGES     = 2,
  parameter logic [15:0]        SOF_WORD        = 16'h8000,
  parameter logic signed [15:0] PWM_REF_INIT    = 16'sd500,
  parameter int                 WATCHDOG_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  input  logic signed [31:0]  actual_position,
  input  logic signed [15:0]  actual_velocity,
  input  logic signed [15:0]  actual_current,
  input  logic signed [15:0]  spring_displacement,
  input  logic signed [15:0]  sensor1,
  input  logic signed [15:0]  sensor2,
  output logic signed [15:0]  pwm_ref,
  output logic        [15:0]  control_flags1,
  output logic        [15:0]  control_flags2,
  output logic                active,
  output logic                frame_valid,
  output logic                frame_error,
  output logic                watchdog_tripped
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_prev, ss_prev;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t      state;
  logic [3:0]  bit_cnt, word_cnt, slot_next;
  logic [14:0] rx_shift;
  logic [15:0] rx_next, tx_shift, reply_word;
  logic [15:0] pending_pwm, pending_f1, pending_f2;
  logic [31:0] pos_shadow;
  logic [15:0] vel_shadow, cur_shadow, spr_shadow, s1_shadow, s2_shadow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign rx_next   = {rx_shift, mosi_s};
  assign miso      = tx_shift[15];

  // Reply for the slot that starts once the current word completes; word_cnt saturates at 13.
  always_comb begin
    slot_next  = (word_cnt == 4'd13) ? 4'd13 : word_cnt + 4'd1;
    reply_word = 16'h0000;
    case (slot_next)
      4'd5:    reply_word = pos_shadow[31:16];
      4'd6:    reply_word = pos_shadow[15:0];
      4'd7:    reply_word = vel_shadow;
      4'd8:    reply_word = cur_shadow;
      4'd9:    reply_word = spr_shadow;
      4'd10:   reply_word = s1_shadow;
      4'd11:   reply_word = s2_shadow;
      default: reply_word = 16'h0000;
    endcase
  end

`ifdef SPI_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign watchdog_tripped = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      word_cnt       <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      pending_pwm    <= '0;
      pending_f1     <= '0;
      pending_f2     <= '0;
      pos_shadow     <= '0;
      vel_shadow     <= '0;
      cur_shadow     <= '0;
      spr_shadow     <= '0;
      s1_shadow      <= '0;
      s2_shadow      <= '0;
      pwm_ref        <= PWM_REF_INIT;
      control_flags1 <= '0;
      control_flags2 <= '0;
      active         <= 1'b0;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
`ifdef SPI_WATCHDOG_EN
      wd_cnt           <= '0;
      watchdog_tripped <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
`ifdef SPI_WATCHDOG_EN
      if (!watchdog_tripped) begin
        if (wd_cnt == WD_LAST) begin
          watchdog_tripped <= 1'b1;
          pwm_ref          <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
      // ss_n rise wins over any sclk edge seen in the same cycle.
      if (ss_rise) begin
        if (state == RECV && word_cnt == 4'd12 && bit_cnt == 4'd0) begin
          pwm_ref        <= pending_pwm;
          control_flags1 <= pending_f1;
          control_flags2 <= pending_f2;
          frame_valid    <= 1'b1;
`ifdef SPI_WATCHDOG_EN
          wd_cnt           <= '0;
          watchdog_tripped <= 1'b0;
`endif
        end else begin
          frame_error <= 1'b1;
        end
        active   <= 1'b0;
        tx_shift <= '0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              pos_shadow <= actual_position;
              vel_shadow <= actual_velocity;
              cur_shadow <= actual_current;
              spr_shadow <= spring_displacement;
              s1_shadow  <= sensor1;
              s2_shadow  <= sensor2;
              tx_shift   <= '0;
              bit_cnt    <= '0;
              word_cnt   <= '0;
              active     <= 1'b1;
              state      <= RECV;
            end
          end
          RECV: begin
            if (sclk_rise) begin
              rx_shift <= rx_next[14:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                if (word_cnt == 4'd0 && rx_next != SOF_WORD) begin
                  tx_shift <= '0;
                  state    <= DISCARD;
                end else begin
                  case (word_cnt)
                    4'd1:    pending_pwm <= rx_next;
                    4'd2:    pending_f1  <= rx_next;
                    4'd3:    pending_f2  <= rx_next;
                    default: ;
                  endcase
                  word_cnt <= slot_next;
                  tx_shift <= reply_word;
                end
              end
            end else if (sclk_fall && bit_cnt != 4'd0) begin
              tx_shift <= {tx_shift[14:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_motor_frame_responder.sv
// Directed-frame bench: an SPI master task drives frames, a monitor scores commit/reject pulses against an expectation queue.
module tb_spi_motor_frame_responder;

  logic clock, reset_n, sclk, ss_n, mosi, miso;
  logic signed [31:0] actual_position;
  logic signed [15:0] actual_velocity, actual_current, spring_displacement, sensor1, sensor2;
  logic signed [15:0] pwm_ref;
  logic [15:0] control_flags1, control_flags2;
  logic active, frame_valid, frame_error, watchdog_tripped;

  spi_motor_frame_responder dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .actual_position(actual_position), .actual_velocity(actual_velocity),
    .actual_current(actual_current), .spring_displacement(spring_displacement),
    .sensor1(sensor1), .sensor2(sensor2),
    .pwm_ref(pwm_ref), .control_flags1(control_flags1), .control_flags2(control_flags2),
    .active(active), .frame_valid(frame_valid), .frame_error(frame_error),
    .watchdog_tripped(watchdog_tripped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        commit;
    logic [15:0] pwm;
    logic [15:0] f1;
    logic [15:0] f2;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tx_words [0:12];
  logic [15:0] exp_miso [0:12];

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  // Monitor: every frame_valid/frame_error pulse is matched against the next expected outcome.
  always @(negedge clock) begin
    if (frame_valid || frame_error) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse valid=%b error=%b exp=none", frame_valid, frame_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame %s pwm_ref=%h flags1=%h flags2=%h",
                 frame_valid ? "commit" : "reject", pwm_ref, control_flags1, control_flags2);
        check16("pulse_kind", {14'd0, frame_valid, frame_error}, {14'd0, e.commit, ~e.commit});
        check16("pwm_ref", pwm_ref, e.pwm);
        check16("flags1", control_flags1, e.f1);
        check16("flags2", control_flags2, e.f2);
      end
    end
  end

  task automatic set_words(input logic [15:0] w0, w1, w2, w3);
    for (int i = 0; i < 13; i++) tx_words[i] = 16'h0000;
    tx_words[0] = w0; tx_words[1] = w1; tx_words[2] = w2; tx_words[3] = w3;
  endtask

  task automatic set_status(input logic [31:0] p, input logic [15:0] v, c, s, a, b);
    actual_position = p; actual_velocity = v; actual_current = c;
    spring_displacement = s; sensor1 = a; sensor2 = b;
  endtask

  task automatic load_exp(input logic [31:0] p, input logic [15:0] v, c, s, a, b);
    for (int i = 0; i < 13; i++) exp_miso[i] = 16'h0000;
    exp_miso[5] = p[31:16]; exp_miso[6] = p[15:0]; exp_miso[7] = v;
    exp_miso[8] = c; exp_miso[9] = s; exp_miso[10] = a; exp_miso[11] = b;
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    #80 sclk = 1'b1;
    m = miso;
    #80 sclk = 1'b0;
  endtask

  task automatic run_frame(input int nwords, input int extra_bits, input bit chk_miso,
                           input bit change_status, input exp_t e);
    logic [15:0] cap;
    logic m;
    ss_n = 1'b0;
    #160;
    check16("active_in_frame", {15'd0, active}, 16'd1);
    if (change_status)
      set_status(32'hDEADBEEF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
    for (int w = 0; w < nwords; w++) begin
      cap = 16'h0000;
      for (int b = 15; b >= 0; b--) begin
        send_bit(tx_words[w][b], m);
        cap[b] = m;
      end
      if (chk_miso) check16($sformatf("miso_word%0d", w), cap, exp_miso[w]);
    end
    for (int b = 0; b < extra_bits; b++) send_bit(1'b1, m);
    exp_q.push_back(e);
    #80 ss_n = 1'b1;
    #400;
    check16("active_after_frame", {15'd0, active}, 16'd0);
    check16("miso_idle", {15'd0, miso}, 16'd0);
  endtask

  initial begin
    exp_t e;
    logic m;
    reset_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    set_status(32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #52 reset_n = 1'b1;
    #100;
    check16("rst_pwm_ref", pwm_ref, 16'd500);
    check16("rst_flags1", control_flags1, 16'h0000);
    check16("rst_flags2", control_flags2, 16'h0000);
    check16("rst_outs", {11'd0, miso, active, frame_valid, frame_error, watchdog_tripped}, 16'h0000);

    // Nominal frame with the spec status pattern.
    set_status(32'h12345678, 16'hFFFE, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    load_exp(32'h12345678, 16'hFFFE, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    set_words(16'h8000, 16'h01F4, 16'h0003, 16'h0005);
    e = '{1'b1, 16'h01F4, 16'h0003, 16'h0005};
    run_frame(12, 0, 1'b1, 1'b0, e);

    // Different values, non-zero dummy and trailing words must be ignored.
    set_status(32'h89ABCDEF, 16'h8001, 16'h7FFF, 16'h00FF, 16'hF00F, 16'h0F0F);
    load_exp(32'h89ABCDEF, 16'h8001, 16'h7FFF, 16'h00FF, 16'hF00F, 16'h0F0F);
    set_words(16'h8000, 16'hFF38, 16'h00A5, 16'h5A00);
    tx_words[4] = 16'h1111; tx_words[7] = 16'hAAAA; tx_words[11] = 16'h5555;
    e = '{1'b1, 16'hFF38, 16'h00A5, 16'h5A00};
    run_frame(12, 0, 1'b1, 1'b0, e);

    // Bad start word: reject, miso stays 0 all frame.
    for (int i = 0; i < 13; i++) exp_miso[i] = 16'h0000;
    set_words(16'h7FFF, 16'h1234, 16'h0F0F, 16'hF0F0);
    e = '{1'b0, 16'hFF38, 16'h00A5, 16'h5A00};
    run_frame(12, 0, 1'b1, 1'b0, e);

    // Short frame (11 words) and partial word after 12 words.
    load_exp(32'h89ABCDEF, 16'h8001, 16'h7FFF, 16'h00FF, 16'hF00F, 16'h0F0F);
    set_words(16'h8000, 16'h0101, 16'h0202, 16'h0303);
    run_frame(11, 0, 1'b1, 1'b0, e);
    run_frame(12, 5, 1'b1, 1'b0, e);

    // Recovery: a valid frame commits normally.
    set_words(16'h8000, 16'h0ABC, 16'h0001, 16'h0002);
    e = '{1'b1, 16'h0ABC, 16'h0001, 16'h0002};
    run_frame(12, 0, 1'b1, 1'b0, e);

    // Overrun: 13 words rejected, 13th reply slot is 0.
    set_words(16'h8000, 16'h7777, 16'h0007, 16'h0070);
    e = '{1'b0, 16'h0ABC, 16'h0001, 16'h0002};
    run_frame(13, 0, 1'b1, 1'b0, e);

    // Status changes after ss_n falls: replies keep the snapshot.
    set_status(32'hCAFE0123, 16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0, 16'h0E0E);
    load_exp(32'hCAFE0123, 16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0, 16'h0E0E);
    set_words(16'h8000, 16'h0042, 16'h0010, 16'h0020);
    e = '{1'b1, 16'h0042, 16'h0010, 16'h0020};
    run_frame(12, 0, 1'b1, 1'b1, e);

    // Reset mid-frame: immediate abort to reset values, no pulse.
    ss_n = 1'b0;
    #160;
    for (int b = 0; b < 20; b++) send_bit(b[0], m);
    reset_n = 1'b0;
    #4;
    check16("abort_pwm_ref", pwm_ref, 16'd500);
    check16("abort_flags1", control_flags1, 16'h0000);
    check16("abort_active", {15'd0, active}, 16'd0);
    ss_n = 1'b1; sclk = 1'b0;
    #96 reset_n = 1'b1;
    #300;
    check16("post_abort_pwm_ref", pwm_ref, 16'd500);
    check16("post_abort_active", {15'd0, active}, 16'd0);

    set_words(16'h8000, 16'h0123, 16'h0456, 16'h0789);
    e = '{1'b1, 16'h0123, 16'h0456, 16'h0789};
    run_frame(12, 0, 1'b0, 1'b0, e);

    #500;
    check16("pending_expectations", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
